// File: rtl/oc_pkg.sv
// Shared defaults, field positions and types for the operand-collector dispatch controller.
package oc_pkg;

  localparam int DEF_NUM_OC        = 4;
  localparam int DEF_NUM_WARP      = 8;
  localparam int DEF_REGS_PER_WARP = 8;
  localparam int DEF_NUM_BANK      = 4;
  localparam int DEF_NUM_ROW       = 16;

  localparam int DEF_BANK_W = $clog2(DEF_NUM_BANK);
  localparam int DEF_ROW_W  = $clog2(DEF_NUM_ROW);

  localparam int SRC_A_LSB = 21;
  localparam int SRC_B_LSB = 16;

  typedef struct packed {
    logic [DEF_ROW_W-1:0]  row;
    logic [DEF_BANK_W-2:0] bank_hi;
  } lut_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_t;

endpackage

// File: rtl/oc_rr_pick.sv
// Round-robin collector picker: first free collector at or after rr_ptr, wrapping.
module oc_rr_pick
  import oc_pkg::*;
#(
  parameter  int NUM_OC = DEF_NUM_OC,
  localparam int OC_W   = $clog2(NUM_OC)
) (
  input  logic [NUM_OC-1:0] oc_empty,
  input  logic [OC_W-1:0]   rr_ptr,
  output logic [OC_W-1:0]   sel,
  output logic              any
);

  logic [NUM_OC-1:0] rotated;
  logic [OC_W-1:0]   first;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      rotated[i] = oc_empty[rr_ptr + OC_W'(i)];
    end
    first = '0;
    for (int i = NUM_OC - 1; i >= 0; i--) begin
      if (rotated[i]) first = OC_W'(i);
    end
    sel = first + rr_ptr;
    any = |oc_empty;
  end

endmodule

// File: rtl/oc_dispatch_ctrl.sv
// Operand-collector dispatch: allocates a collector, maps sources through a writable
// bank/row LUT and emits one or two bank-read beats depending on bank conflicts.
module oc_dispatch_ctrl
  import oc_pkg::*;
#(
  parameter  int NUM_OC        = DEF_NUM_OC,
  parameter  int NUM_WARP      = DEF_NUM_WARP,
  parameter  int REGS_PER_WARP = DEF_REGS_PER_WARP,
  parameter  int NUM_BANK      = DEF_NUM_BANK,
  parameter  int NUM_ROW       = DEF_NUM_ROW,
  localparam int OC_W          = $clog2(NUM_OC),
  localparam int WARP_W        = $clog2(NUM_WARP),
  localparam int BANK_W        = $clog2(NUM_BANK),
  localparam int ROW_W         = $clog2(NUM_ROW),
  localparam int LUT_DEPTH     = NUM_WARP * REGS_PER_WARP / 2,
  localparam int LUT_AW        = $clog2(LUT_DEPTH),
  localparam int LUT_DW        = ROW_W + BANK_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IU_OC_valid,
  output logic              IU_OC_ready,
  input  logic [31:0]       IU_OC_Instr,
  input  logic [WARP_W-1:0] IU_OC_HWWarp,
  input  logic [NUM_OC-1:0] oc_empty,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_addr,
  input  logic [LUT_DW-1:0] lut_wdata,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ROW_W-1:0]  rowid_a,
  output logic [ROW_W-1:0]  rowid_b,
  output logic [BANK_W-1:0] bankid_a,
  output logic [BANK_W-1:0] bankid_b,
  output logic              req_a_en,
  output logic              req_b_en,
  output logic              req_dup,
  output logic              ReqFIFO_2op_EN,
  output logic [OC_W-1:0]   IU_OC_ocid,
  output logic [NUM_OC-1:0] oc_alloc
);

  // A two-bank configuration has no bank_hi bits; the field is kept one bit wide and tied to 0.
  localparam int HI_W = (BANK_W > 1) ? BANK_W - 1 : 1;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [HI_W-1:0]  bank_hi;
  } entry_t;

  entry_t lut [LUT_DEPTH];

  state_t            state;
  logic [OC_W-1:0]   rr_ptr;
  logic [OC_W-1:0]   sel;
  logic              any_free;
  logic              accept;

  logic [2:0]        src_a;
  logic [2:0]        src_b;
  logic [LUT_AW-1:0] idx_a;
  logic [LUT_AW-1:0] idx_b;
  entry_t            ent_a;
  entry_t            ent_b;
  logic [BANK_W-1:0] bank_a_d;
  logic [BANK_W-1:0] bank_b_d;

  logic [ROW_W-1:0]  row_a_q;
  logic [ROW_W-1:0]  row_b_q;
  logic [BANK_W-1:0] bank_a_q;
  logic [BANK_W-1:0] bank_b_q;
  logic              dup_q;
  logic              two_op_q;
  logic [OC_W-1:0]   ocid_q;
  logic [NUM_OC-1:0] alloc_q;

  logic              unused_instr_bits;
  assign unused_instr_bits = ^IU_OC_Instr;

  function automatic logic [LUT_AW-1:0] lut_index(input logic [WARP_W-1:0] warp,
                                                   input logic [2:0]        src);
    return LUT_AW'(warp) * LUT_AW'(REGS_PER_WARP / 2) + LUT_AW'(src[2:1]);
  endfunction

  oc_rr_pick #(.NUM_OC(NUM_OC)) u_rr_pick (
    .oc_empty (oc_empty),
    .rr_ptr   (rr_ptr),
    .sel      (sel),
    .any      (any_free)
  );

  assign IU_OC_ready = rst && (state == IDLE) && any_free;
  assign accept      = IU_OC_valid && IU_OC_ready;

  assign src_a    = IU_OC_Instr[SRC_A_LSB +: 3];
  assign src_b    = IU_OC_Instr[SRC_B_LSB +: 3];
  assign idx_a    = lut_index(IU_OC_HWWarp, src_a);
  assign idx_b    = lut_index(IU_OC_HWWarp, src_b);
  assign ent_a    = lut[idx_a];
  assign ent_b    = lut[idx_b];
  assign bank_a_d = BANK_W'({ent_a.bank_hi, src_a[0]});
  assign bank_b_d = BANK_W'({ent_b.bank_hi, src_b[0]});

  // Reset restores the identity map; a write lands on the edge, so a same-cycle decode sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 0; e < LUT_DEPTH; e++) begin
        lut[e].row     <= ROW_W'(e / (NUM_BANK / 2));
        lut[e].bank_hi <= HI_W'(e % (NUM_BANK / 2));
      end
    end else if (lut_we) begin
      lut[lut_addr].row     <= lut_wdata[LUT_DW-1 -: ROW_W];
      lut[lut_addr].bank_hi <= (BANK_W > 1) ? HI_W'(lut_wdata) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      ocid_q   <= '0;
      alloc_q  <= '0;
      row_a_q  <= '0;
      row_b_q  <= '0;
      bank_a_q <= '0;
      bank_b_q <= '0;
      dup_q    <= 1'b0;
      two_op_q <= 1'b0;
    end else begin
      alloc_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BEAT1;
            rr_ptr   <= sel + OC_W'(1);
            ocid_q   <= sel;
            alloc_q  <= NUM_OC'(1) << sel;
            row_a_q  <= ent_a.row;
            row_b_q  <= ent_b.row;
            bank_a_q <= bank_a_d;
            bank_b_q <= bank_b_d;
            dup_q    <= (src_a == src_b);
            two_op_q <= (src_a != src_b) && (bank_a_d != bank_b_d);
          end
        end
        BEAT1: begin
          if (req_ready) state <= (dup_q || two_op_q) ? IDLE : BEAT2;
        end
        BEAT2: begin
          if (req_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_valid      = rst && (state != IDLE);
  assign req_a_en       = req_valid && (state == BEAT1);
  assign req_b_en       = req_valid && (((state == BEAT1) && two_op_q) || (state == BEAT2));
  assign req_dup        = req_a_en && dup_q;
  assign ReqFIFO_2op_EN = req_a_en && req_b_en;

  assign rowid_a    = row_a_q;
  assign rowid_b    = row_b_q;
  assign bankid_a   = bank_a_q;
  assign bankid_b   = bank_b_q;
  assign IU_OC_ocid = ocid_q;
  assign oc_alloc   = alloc_q;

endmodule
